pp_accumulator: RTL and testbench
=================================

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 The block SHALL take parameter LANES, default 2, giving the number of partial products summed per accumulate cycle; legal values are 1, 2, 4, 8.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; reset SHALL be synchronous and active-low.
REQ-004 Port in_valid, input, 1, high when the upstream partial-product set p0..p15 is valid.
REQ-005 Port in_ready, output, 1, high when the block accepts a new set.
REQ-006 Ports p0..p15, input, 32 each, the shifted/gated partial products from the upstream partial_products stage.
REQ-007 Port out_valid, output, 1, high when product holds a finished result.
REQ-008 Port out_ready, input, 1, downstream accept.
REQ-009 Port product, output, 32, the sum of the accepted p0..p15, modulo 2^32.
REQ-010 Port busy, output, 1, high in ACCUM or DONE.

Function
REQ-011 The block SHALL implement three states: IDLE, ACCUM and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; an input handshake occurs on an edge where in_valid and in_ready are both 1.
REQ-013 On a handshake at edge T, the block SHALL register p0..p15 into an internal bank, clear the accumulator and group index, and enter ACCUM.
REQ-014 Each ACCUM cycle SHALL add LANES consecutive bank entries (index idx..idx+LANES-1) to the accumulator and advance idx by LANES.
REQ-015 After the group starting at 16-LANES is added, the block SHALL enter DONE with product = final sum and out_valid = 1.
REQ-016 Without the optional feature, out_valid SHALL first be high in the cycle after edge T+16/LANES, i.e. 8 accumulate edges after capture for LANES=2.
REQ-017 In DONE, product and out_valid SHALL hold stable until out_valid and out_ready are both 1; on that edge the block SHALL return to IDLE and drop out_valid.
REQ-018 in_valid while not in IDLE SHALL be ignored, and p0..p15 changes after capture SHALL NOT affect the result.
REQ-019 All additions SHALL be 32-bit unsigned with carry-out discarded.

Reset
REQ-020 While rst_n is low at a clock edge, the block SHALL enter IDLE with product = 0, out_valid = 0, busy = 0, accumulator = 0 and idx = 0; in_ready SHALL be 0 while rst_n is low.
REQ-021 Reset asserted during ACCUM or DONE SHALL discard the operation in progress; no result for it SHALL ever be presented.

Configuration
REQ-022 Macro PP_ACCUMULATOR_ZERO_SKIP_EN: when defined, a group whose LANES captured entries are all zero SHALL consume no cycle; latency becomes T+1+G, where G is the number of non-zero groups.
REQ-023 With PP_ACCUMULATOR_ZERO_SKIP_EN defined and G = 0, the block SHALL go from capture straight to DONE, with product = 0 valid after edge T+1.
REQ-024 Without the macro, latency SHALL be fixed as in REQ-016 regardless of data.

Structure
REQ-025 Package pp_acc_pkg SHALL hold the state enum, NUM_PP = 16 and PP_W = 32.
REQ-026 The LANES-input combinational adder SHALL be a sub-module named pp_group_adder; FSM, bank and zero-mask logic stay in pp_accumulator.

Verification
REQ-027 LANES=2, partial products of a=16'h1234, b=16'h5678, out_ready=1 -> product = 32'h06260060 with out_valid first high after edge T+8.
REQ-028 Partial products of a=16'hFFFF, b=16'hFFFF, with out_ready held low 5 cycles -> product = 32'hFFFE0001 held stable and in_ready = 0 throughout; return to IDLE one edge after out_ready rises.
REQ-029 All partial products zero (b=0) -> product = 0; out_valid after edge T+8 without the macro, after edge T+1 with it.
REQ-030 rst_n low for one edge at T+4 during ACCUM -> out_valid stays 0, in_ready = 1 after release, and the next operation gives the correct product with no stale accumulation.
REQ-031 in_valid pulsed with different p values while busy -> ignored; the result equals the captured set only.
REQ-032 LANES=1 and LANES=4 with a=16'h00FF, b=16'h0101 -> product = 32'h0000FFFF at T+16 and T+4 respectively.

Source files
------------

// File: rtl/pp_acc_pkg.sv
// Shared types and constants for the partial-product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pp_acc_pkg;

    // Number of partial products per operation and their width
    localparam int NUM_PP = 16;
    localparam int PP_W   = 32;
    localparam int IDX_W  = $clog2(NUM_PP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pp_state_e;

    // Number of LANES-wide groups the bank splits into
    function automatic int num_groups(input int lanes);
        return NUM_PP / lanes;
    endfunction

endpackage

// File: rtl/pp_group_adder.sv
// Adds LANES partial products onto a running base value, 32-bit wraparound.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the sum is registered.
module pp_group_adder
    import pp_acc_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [PP_W-1:0]       base_i,
    input  logic [LANES*PP_W-1:0] terms_i,
    output logic [PP_W-1:0]       sum_o
);

    // Chain of LANES adders; carry-out beyond PP_W bits is dropped
    always_comb begin
        sum_o = base_i;
        for (int l = 0; l < LANES; l++) begin
            sum_o = sum_o + terms_i[l*PP_W +: PP_W];
        end
    end

endmodule

// File: rtl/pp_accumulator.sv
// Captures 16 partial products and sums LANES of them per cycle into product.
// Latency: result valid the cycle after edge T+16/LANES (T+1+G with PP_ACCUMULATOR_ZERO_SKIP_EN).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module pp_accumulator
    import pp_acc_pkg::*;
#(
    parameter int LANES = 2   // legal: 1, 2, 4, 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PP_W-1:0] p0,
    input  logic [PP_W-1:0] p1,
    input  logic [PP_W-1:0] p2,
    input  logic [PP_W-1:0] p3,
    input  logic [PP_W-1:0] p4,
    input  logic [PP_W-1:0] p5,
    input  logic [PP_W-1:0] p6,
    input  logic [PP_W-1:0] p7,
    input  logic [PP_W-1:0] p8,
    input  logic [PP_W-1:0] p9,
    input  logic [PP_W-1:0] p10,
    input  logic [PP_W-1:0] p11,
    input  logic [PP_W-1:0] p12,
    input  logic [PP_W-1:0] p13,
    input  logic [PP_W-1:0] p14,
    input  logic [PP_W-1:0] p15,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PP_W-1:0] product,
    output logic            busy
);

    localparam int               NUM_GRP  = num_groups(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - LANES);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    pp_state_e             state_q;
    logic [PP_W-1:0]       p_in   [NUM_PP];
    logic [PP_W-1:0]       bank_q [NUM_PP];
    logic [PP_W-1:0]       acc_q;
    logic [PP_W-1:0]       acc_d;
    logic [PP_W-1:0]       product_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      cur_idx;
    logic                  out_valid_q;
    logic [LANES*PP_W-1:0] grp_terms;
    logic                  hs;

    // Gather the flat input ports into an indexable array
    always_comb begin
        p_in[0]  = p0;
        p_in[1]  = p1;
        p_in[2]  = p2;
        p_in[3]  = p3;
        p_in[4]  = p4;
        p_in[5]  = p5;
        p_in[6]  = p6;
        p_in[7]  = p7;
        p_in[8]  = p8;
        p_in[9]  = p9;
        p_in[10] = p10;
        p_in[11] = p11;
        p_in[12] = p12;
        p_in[13] = p13;
        p_in[14] = p14;
        p_in[15] = p15;
    end

    // Ready is gated by reset so nothing is accepted while rst_n is low
    assign in_ready  = rst_n && (state_q == IDLE);
    assign hs        = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = (state_q != IDLE);

    // Bank snapshot: later changes on p0..p15 cannot disturb an operation
    always_ff @(posedge clk) begin
        if (hs) begin
            for (int i = 0; i < NUM_PP; i++) begin
                bank_q[i] <= p_in[i];
            end
        end
    end

    // Select the LANES consecutive bank entries starting at cur_idx
    always_comb begin
        grp_terms = '0;
        for (int l = 0; l < LANES; l++) begin
            grp_terms[l*PP_W +: PP_W] = bank_q[cur_idx + IDX_W'(l)];
        end
    end

    pp_group_adder #(
        .LANES (LANES)
    ) u_group_adder (
        .base_i  (acc_q),
        .terms_i (grp_terms),
        .sum_o   (acc_d)
    );

`ifdef PP_ACCUMULATOR_ZERO_SKIP_EN
    // Remaining non-zero groups; one scan cycle after capture loads it
    logic [NUM_GRP-1:0] mask_q;
    logic [NUM_GRP-1:0] nz_mask;
    logic [NUM_GRP-1:0] mask_clr;
    logic [IDX_W-1:0]   sel_grp;
    logic               scan_q;

    // A group is live if any of its LANES captured entries is non-zero
    always_comb begin
        nz_mask = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int l = 0; l < LANES; l++) begin
                nz_mask[g] = nz_mask[g] | (|bank_q[g*LANES + l]);
            end
        end
    end

    // Lowest remaining live group is processed next
    always_comb begin
        sel_grp = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            if (mask_q[g]) begin
                sel_grp = IDX_W'(g);
            end
        end
        cur_idx           = sel_grp * IDX_STEP;
        mask_clr          = mask_q;
        mask_clr[sel_grp] = 1'b0;
    end
`else
    assign cur_idx = idx_q;
`endif

    // Control FSM with registered result and valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef PP_ACCUMULATOR_ZERO_SKIP_EN
            mask_q      <= '0;
            scan_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACCUM;
`ifdef PP_ACCUMULATOR_ZERO_SKIP_EN
                        scan_q  <= 1'b1;
`endif
                    end
                end
                ACCUM: begin
`ifdef PP_ACCUMULATOR_ZERO_SKIP_EN
                    if (scan_q) begin
                        scan_q <= 1'b0;
                        mask_q <= nz_mask;
                        // All groups zero: the (cleared) accumulator is the answer
                        if (nz_mask == '0) begin
                            product_q   <= acc_q;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        acc_q  <= acc_d;
                        idx_q  <= cur_idx + IDX_STEP;
                        mask_q <= mask_clr;
                        if (mask_clr == '0) begin
                            product_q   <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
`else
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDX_STEP;
                    if (idx_q == LAST_IDX) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench: three instances (LANES = 2, 1, 4) sharing data, reset and out_ready.
// Each scenario task checks against a sum-of-products reference model.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_pp_accumulator;

`ifdef PP_ACCUMULATOR_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic        iv2, iv1, iv4;
    logic [31:0] p_drv [16];

    logic        rdy2, rdy1, rdy4;
    logic        ov2, ov1, ov4;
    logic        busy2, busy1, busy4;
    logic [31:0] prod2, prod1, prod4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pp_accumulator #(.LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(rdy2),
        .p0(p_drv[0]), .p1(p_drv[1]), .p2(p_drv[2]), .p3(p_drv[3]),
        .p4(p_drv[4]), .p5(p_drv[5]), .p6(p_drv[6]), .p7(p_drv[7]),
        .p8(p_drv[8]), .p9(p_drv[9]), .p10(p_drv[10]), .p11(p_drv[11]),
        .p12(p_drv[12]), .p13(p_drv[13]), .p14(p_drv[14]), .p15(p_drv[15]),
        .out_valid(ov2), .out_ready(out_ready), .product(prod2), .busy(busy2)
    );

    pp_accumulator #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .p0(p_drv[0]), .p1(p_drv[1]), .p2(p_drv[2]), .p3(p_drv[3]),
        .p4(p_drv[4]), .p5(p_drv[5]), .p6(p_drv[6]), .p7(p_drv[7]),
        .p8(p_drv[8]), .p9(p_drv[9]), .p10(p_drv[10]), .p11(p_drv[11]),
        .p12(p_drv[12]), .p13(p_drv[13]), .p14(p_drv[14]), .p15(p_drv[15]),
        .out_valid(ov1), .out_ready(out_ready), .product(prod1), .busy(busy1)
    );

    pp_accumulator #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .p0(p_drv[0]), .p1(p_drv[1]), .p2(p_drv[2]), .p3(p_drv[3]),
        .p4(p_drv[4]), .p5(p_drv[5]), .p6(p_drv[6]), .p7(p_drv[7]),
        .p8(p_drv[8]), .p9(p_drv[9]), .p10(p_drv[10]), .p11(p_drv[11]),
        .p12(p_drv[12]), .p13(p_drv[13]), .p14(p_drv[14]), .p15(p_drv[15]),
        .out_valid(ov4), .out_ready(out_ready), .product(prod4), .busy(busy4)
    );

    // ---------------- instance access (sel 0: LANES=2, 1: LANES=1, 2: LANES=4)
    function automatic int lanes_of(input int sel);
        case (sel)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic get_rdy(input int sel);
        case (sel)
            1:       return rdy1;
            2:       return rdy4;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_ov(input int sel);
        case (sel)
            1:       return ov1;
            2:       return ov4;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int sel);
        case (sel)
            1:       return prod1;
            2:       return prod4;
            default: return prod2;
        endcase
    endfunction

    task automatic set_iv(input int sel, input logic v);
        case (sel)
            1:       iv1 = v;
            2:       iv4 = v;
            default: iv2 = v;
        endcase
    endtask

    // ---------------- reference model
    // Product of the operation is simply the wrapped sum of all 16 entries
    function automatic logic [31:0] model_sum(input logic [31:0] pv [16]);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < 16; i++) s = s + pv[i];
        return s;
    endfunction

    // Edges from capture to the edge after which out_valid is first high
    function automatic int model_lat(input logic [31:0] pv [16], input int lanes);
        int g = 0;
        for (int grp = 0; grp < 16 / lanes; grp++) begin
            logic nz = 1'b0;
            for (int l = 0; l < lanes; l++) nz = nz | (pv[grp*lanes + l] != 32'd0);
            if (nz) g++;
        end
        return SKIP ? (1 + g) : (16 / lanes);
    endfunction

    // Shift-and-gate partial products of a 16x16 multiply
    task automatic pp_set(input logic [15:0] a, input logic [15:0] b, output logic [31:0] pv [16]);
        for (int i = 0; i < 16; i++) pv[i] = b[i] ? ({16'd0, a} << i) : 32'd0;
    endtask

    // ---------------- driver: handshake one set, scramble inputs, wait for result
    task automatic do_op(input int sel, input logic [31:0] pv [16],
                         output logic [31:0] prod, output int lat);
        bit ok = 1'b0;
        prod = 'x;
        lat  = -1;
        p_drv = pv;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (get_rdy(sel) === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            set_iv(sel, 1'b1);
            @(posedge clk); #1;
            set_iv(sel, 1'b0);
            for (int i = 0; i < 16; i++) p_drv[i] = $urandom;
            for (int k = 1; k <= 64; k++) begin
                @(posedge clk); #1;
                if (get_ov(sel) === 1'b1) begin
                    lat  = k;
                    prod = get_prod(sel);
                    break;
                end
            end
        end
    endtask

    task automatic wait_idle(input int sel);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (get_rdy(sel) === 1'b1) break;
        end
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        iv2 = 1'b0; iv1 = 1'b0; iv4 = 1'b0;
        for (int i = 0; i < 16; i++) p_drv[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rdy2, rdy1, rdy4} !== 3'b000) $display("FAIL reset_in_ready: got %b expected 000", {rdy2, rdy1, rdy4});
        else n_pass++;
        n_checks++;
        if ({ov2, ov1, ov4} !== 3'b000) $display("FAIL reset_out_valid: got %b expected 000", {ov2, ov1, ov4});
        else n_pass++;
        n_checks++;
        if ({busy2, busy1, busy4} !== 3'b000) $display("FAIL reset_busy: got %b expected 000", {busy2, busy1, busy4});
        else n_pass++;
        n_checks++;
        if (prod2 !== 32'd0) $display("FAIL reset_product: got %h expected 00000000", prod2);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({rdy2, rdy1, rdy4} !== 3'b111) $display("FAIL reset_release_ready: got %b expected 111", {rdy2, rdy1, rdy4});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        out_ready = 1'b1;
        pp_set(16'h1234, 16'h5678, pv);
        do_op(0, pv, prod, lat);
        n_checks++;
        if (prod !== 32'h06260060) $display("FAIL basic_product: got %h expected 06260060", prod);
        else n_pass++;
        n_checks++;
        if (lat != model_lat(pv, 2)) $display("FAIL basic_latency: got %0d expected %0d", lat, model_lat(pv, 2));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({ov2, rdy2, busy2} !== 3'b010) $display("FAIL basic_retire: got ov/rdy/busy %b expected 010", {ov2, rdy2, busy2});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        pp_set(16'hFFFF, 16'hFFFF, pv);
        do_op(0, pv, prod, lat);
        n_checks++;
        if (prod !== 32'hFFFE0001) $display("FAIL bp_product: got %h expected fffe0001", prod);
        else n_pass++;
        n_checks++;
        if (lat != model_lat(pv, 2)) $display("FAIL bp_latency: got %0d expected %0d", lat, model_lat(pv, 2));
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ov2 !== 1'b1 || prod2 !== 32'hFFFE0001 || rdy2 !== 1'b0 || busy2 !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ov2, rdy2, busy2} !== 3'b010) $display("FAIL bp_release: got ov/rdy/busy %b expected 010", {ov2, rdy2, busy2});
        else n_pass++;
    endtask

    task automatic test_zero();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        out_ready = 1'b1;
        pp_set(16'h1234, 16'h0000, pv);
        do_op(0, pv, prod, lat);
        n_checks++;
        if (prod !== 32'd0) $display("FAIL zero_product: got %h expected 00000000", prod);
        else n_pass++;
        n_checks++;
        if (lat != (SKIP ? 1 : 8)) $display("FAIL zero_latency: got %0d expected %0d", lat, SKIP ? 1 : 8);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        wait_idle(0);
        pp_set(16'hBEEF, 16'hCAFE, pv);
        p_drv = pv;
        iv2 = 1'b1;
        @(posedge clk); #1;          // edge T: capture
        iv2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;                // sampled at edge T+4
        #3;
        n_checks++;
        if (rdy2 !== 1'b0) $display("FAIL midreset_ready_low: got %b expected 0", rdy2);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdy2 !== 1'b1) $display("FAIL midreset_ready_after: got %b expected 1", rdy2);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ov2 !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL midreset_no_result: got %0d valid cycles expected 0", seen);
        else n_pass++;
        pp_set(16'h0102, 16'h0304, pv);
        do_op(0, pv, prod, lat);
        n_checks++;
        if (prod !== 32'h0003_0A08) $display("FAIL midreset_next_product: got %h expected 00030a08", prod);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        logic [31:0] pv [16];
        int bad = 0;
        int lat = -1;
        logic [31:0] prod = 'x;
        out_ready = 1'b1;
        wait_idle(0);
        for (int i = 0; i < 16; i++) pv[i] = $urandom | 32'd1;
        p_drv = pv;
        iv2 = 1'b1;
        @(posedge clk); #1;          // edge T: capture
        for (int j = 1; j <= 3; j++) begin
            for (int i = 0; i < 16; i++) p_drv[i] = $urandom;
            @(posedge clk); #1;
            if (rdy2 !== 1'b0) bad++;
        end
        iv2 = 1'b0;
        for (int k = 4; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ov2 === 1'b1) begin lat = k; prod = prod2; break; end
        end
        n_checks++;
        if (bad != 0) $display("FAIL busy_ready_low: got %0d ready cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (prod !== model_sum(pv)) $display("FAIL busy_product: got %h expected %h", prod, model_sum(pv));
        else n_pass++;
        n_checks++;
        if (lat != model_lat(pv, 2)) $display("FAIL busy_latency: got %0d expected %0d", lat, model_lat(pv, 2));
        else n_pass++;
    endtask

    task automatic test_lanes();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        out_ready = 1'b1;
        pp_set(16'h00FF, 16'h0101, pv);
        do_op(1, pv, prod, lat);
        n_checks++;
        if (prod !== 32'h0000FFFF) $display("FAIL lanes1_product: got %h expected 0000ffff", prod);
        else n_pass++;
        n_checks++;
        if (lat != model_lat(pv, 1)) $display("FAIL lanes1_latency: got %0d expected %0d", lat, model_lat(pv, 1));
        else n_pass++;
        do_op(2, pv, prod, lat);
        n_checks++;
        if (prod !== 32'h0000FFFF) $display("FAIL lanes4_product: got %h expected 0000ffff", prod);
        else n_pass++;
        n_checks++;
        if (lat != model_lat(pv, 4)) $display("FAIL lanes4_latency: got %0d expected %0d", lat, model_lat(pv, 4));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] pv [16];
        logic [31:0] prod;
        int lat;
        int sel;
        out_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            sel = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                pv[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            do_op(sel, pv, prod, lat);
            n_checks++;
            if (prod !== model_sum(pv))
                $display("FAIL rand_product[%0d] lanes=%0d: got %h expected %h", it, lanes_of(sel), prod, model_sum(pv));
            else n_pass++;
            n_checks++;
            if (lat != model_lat(pv, lanes_of(sel)))
                $display("FAIL rand_latency[%0d] lanes=%0d: got %0d expected %0d", it, lanes_of(sel), lat, model_lat(pv, lanes_of(sel)));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_ignore_busy();
        test_lanes();
        test_random();
        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
